// File: rtl/output_buffer_ctrl_if.sv
// Bus bundle between the output buffer controller and its surroundings:
// array result input, buffer store/send port and the external word port.
interface output_buffer_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data;
    logic              ext_valid;
    logic [DATA_W-1:0] ext_data;
    logic              ext_ready;

    // Handshake: a word moves only on a cycle where ext_valid && ext_ready;
    // ext_valid/ext_data stay stable until then and ext_ready alone means nothing.
    modport master (
        input  res_valid, res_data, buf_rd_data, ext_ready,
        output buf_wr_en, buf_wr_addr, buf_wr_data,
        output buf_rd_en, buf_rd_addr, ext_valid, ext_data
    );

    modport slave (
        output res_valid, res_data, buf_rd_data, ext_ready,
        input  buf_wr_en, buf_wr_addr, buf_wr_data,
        input  buf_rd_en, buf_rd_addr, ext_valid, ext_data
    );
endinterface

// File: rtl/output_buffer_ctrl.sv
// Output buffer sequencer: collects one tile of array results into the buffer,
// then drains them in address order onto the external valid/ready port.
module output_buffer_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_results,
    output_buffer_ctrl_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err_drop,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        PRESENT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     cnt;
    logic [ADDR_W:0]     n_total;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                ext_valid_q;
    logic [DATA_W-1:0]   ext_data_q;
    logic [ADDR_W:0]     cnt_next;
    logic [ADDR_W:0]     rd_next;
    logic [ADDR_W:0]     n_clamped;

    always_comb begin
        cnt_next  = cnt + 1'b1;
        rd_next   = {1'b0, rd_ptr} + 1'b1;
        n_clamped = (num_results > DEPTH_N) ? DEPTH_N : num_results;
    end

    assign bus.buf_wr_en   = bus.res_valid && (state == COLLECT);
    assign bus.buf_wr_addr = wr_ptr;
    assign bus.buf_wr_data = bus.res_data;
    assign bus.buf_rd_en   = rd_en_q;
    assign bus.buf_rd_addr = rd_addr_q;
    assign bus.ext_valid   = ext_valid_q;
    assign bus.ext_data    = ext_data_q;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            n_total     <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            ext_valid_q <= 1'b0;
            ext_data_q  <= '0;
            done        <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_en_q <= 1'b0;
            if (bus.res_valid && state != COLLECT) begin
                err_drop <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        n_total  <= n_clamped;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        cnt      <= '0;
                        err_drop <= 1'b0;
                        if (n_clamped == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.res_valid) begin
                        cnt <= cnt_next;
                        // The last write leaves wr_ptr on its address so a full tile never wraps.
                        if (cnt_next == n_total) begin
                            state     <= RD_ISSUE;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= rd_ptr;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    ext_data_q  <= bus.buf_rd_data;
                    ext_valid_q <= 1'b1;
                    state       <= PRESENT;
                end
                PRESENT: begin
                    if (bus.ext_ready) begin
                        ext_valid_q <= 1'b0;
                        if (rd_next == n_total) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            rd_ptr    <= rd_ptr + 1'b1;
                            rd_addr_q <= rd_ptr + 1'b1;
                            rd_en_q   <= 1'b1;
                            state     <= RD_ISSUE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Directed bench for output_buffer_ctrl with a registered-read buffer model
// and a monitor that scores store addresses and drained words.
module tb_output_buffer_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_results;
    logic              busy;
    logic              done;
    logic              err_drop;
    logic [2:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int exp_wr_addr = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] wr_q[$];
    logic [DATA_W-1:0] mem [16];

    output_buffer_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    output_buffer_ctrl #(.DATA_W(DATA_W), .DEPTH(16), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_results (num_results),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done),
        .err_drop    (err_drop),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // buffer model: registered read, data valid the cycle after buf_rd_en
    always @(posedge clk) begin
        if (bus.buf_wr_en) mem[bus.buf_wr_addr] <= bus.buf_wr_data;
        if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.buf_wr_en) begin
                check("wr_addr", 32'(bus.buf_wr_addr), 32'(exp_wr_addr));
                if (wr_q.size() > 0) check("wr_data", bus.buf_wr_data, wr_q.pop_front());
                else check("wr_unexpected", 32'd1, 32'd0);
                exp_wr_addr++;
                wr_cnt++;
            end
            if (bus.buf_rd_en) rd_cnt++;
            if (bus.buf_wr_en && bus.buf_rd_en) check("wr_rd_excl", 32'd1, 32'd0);
            if (bus.ext_valid && bus.ext_ready) begin
                if (exp_q.size() > 0) check("ext_data", bus.ext_data, exp_q.pop_front());
                else check("ext_unexpected", 32'd1, 32'd0);
                acc_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; acc_cnt = 0; done_cnt = 0;
        exp_q.delete();
        wr_q.delete();
    endtask

    task automatic start_tile(input int n);
        start = 1'b1;
        num_results = (ADDR_W+1)'(n);
        exp_wr_addr = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic send_result(input logic [DATA_W-1:0] d);
        bus.res_valid = 1'b1;
        bus.res_data = d;
        wr_q.push_back(d);
        tick();
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_ext_valid(input string tag, input int budget);
        int k = 0;
        while (!bus.ext_valid && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.ext_valid), 32'd1);
    endtask

    initial begin
        int rd_before;
        rst = 1'b1;
        start = 1'b0;
        num_results = '0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        bus.ext_ready = 1'b0;
        bus.buf_rd_data = '0;
        repeat (3) tick();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_drop), 32'd0);
        check("rst_ext_valid", 32'(bus.ext_valid), 32'd0);
        check("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();

        // reset in the middle of PRESENT
        clear_counts();
        bus.ext_ready = 1'b0;
        exp_q.push_back(32'h55);
        start_tile(1);
        send_result(32'h55);
        wait_ext_valid("mid_present_valid", 10);
        check("mid_present_state", 32'(state_dbg), 32'd4);
        rst = 1'b1;
        #1;
        check("async_rst_ext_valid", 32'(bus.ext_valid), 32'd0);
        check("async_rst_ext_data", bus.ext_data, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // basic tile, N=4
        clear_counts();
        bus.ext_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
        start_tile(4);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_state", 32'(state_dbg), 32'd1);
        for (int i = 0; i < 4; i++) send_result(32'hA0 + 32'(i));
        check("basic_rd_issue", 32'(bus.buf_rd_en), 32'd1);
        check("basic_rd_addr", 32'(bus.buf_rd_addr), 32'd0);
        tick();
        check("basic_lat_wait", 32'(bus.ext_valid), 32'd0);
        tick();
        check("basic_lat_valid", 32'(bus.ext_valid), 32'd1);
        check("basic_first_word", bus.ext_data, 32'hA0);
        wait_idle("basic_idle", 100);
        check("basic_wr_cnt", 32'(wr_cnt), 32'd4);
        check("basic_rd_cnt", 32'(rd_cnt), 32'd4);
        check("basic_acc_cnt", 32'(acc_cnt), 32'd4);
        check("basic_done_cnt", 32'(done_cnt), 32'd1);
        check("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // full buffer, N=20 clamps to 16
        clear_counts();
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
        start_tile(20);
        for (int i = 0; i < 16; i++) send_result(32'h100 + 32'(i));
        check("full_rd_issue", 32'(bus.buf_rd_en), 32'd1);
        wait_idle("full_idle", 200);
        check("full_wr_cnt", 32'(wr_cnt), 32'd16);
        check("full_last_addr", 32'(exp_wr_addr), 32'd16);
        check("full_acc_cnt", 32'(acc_cnt), 32'd16);
        check("full_done_cnt", 32'(done_cnt), 32'd1);
        check("full_q_empty", 32'(exp_q.size()), 32'd0);

        // backpressure on word 1, N=3
        clear_counts();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hB0 + 32'(i));
        start_tile(3);
        for (int i = 0; i < 3; i++) send_result(32'hB0 + 32'(i));
        for (int k = 0; k < 20 && acc_cnt < 1; k++) tick();
        bus.ext_ready = 1'b0;
        wait_ext_valid("bp_word1_valid", 10);
        rd_before = rd_cnt;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(bus.ext_valid), 32'd1);
            check("bp_hold_data", bus.ext_data, 32'hB1);
            tick();
        end
        check("bp_no_extra_rd", 32'(rd_cnt), 32'(rd_before));
        bus.ext_ready = 1'b1;
        wait_idle("bp_idle", 100);
        check("bp_acc_cnt", 32'(acc_cnt), 32'd3);
        check("bp_rd_cnt", 32'(rd_cnt), 32'd3);
        check("bp_q_empty", 32'(exp_q.size()), 32'd0);

        // drop during drain, start while busy ignored
        clear_counts();
        exp_q.push_back(32'hC0);
        exp_q.push_back(32'hC1);
        start_tile(2);
        send_result(32'hC0);
        send_result(32'hC1);
        bus.res_valid = 1'b1;
        bus.res_data = 32'hDEAD;
        start = 1'b1;
        num_results = 5'd7;
        #1;
        check("drop_no_wr", 32'(bus.buf_wr_en), 32'd0);
        tick();
        bus.res_valid = 1'b0;
        start = 1'b0;
        check("drop_err_set", 32'(err_drop), 32'd1);
        check("busy_start_ignored", 32'(state_dbg), 32'd3);
        wait_idle("drop_idle", 100);
        check("drop_wr_cnt", 32'(wr_cnt), 32'd2);
        check("drop_acc_cnt", 32'(acc_cnt), 32'd2);
        check("drop_done_cnt", 32'(done_cnt), 32'd1);
        check("drop_err_sticky", 32'(err_drop), 32'd1);

        // empty tile also clears err_drop
        clear_counts();
        start_tile(0);
        check("empty_err_clear", 32'(err_drop), 32'd0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_state", 32'(state_dbg), 32'd5);
        tick();
        check("empty_done_once", 32'(done), 32'd0);
        check("empty_busy_low", 32'(busy), 32'd0);
        check("empty_no_wr", 32'(wr_cnt), 32'd0);
        check("empty_no_rd", 32'(rd_cnt), 32'd0);
        check("empty_done_cnt", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
